ultrasonic_ranger: RTL and testbench
====================================

// Module: ultrasonic_ranger
// PURPOSE
//  Dual-channel HC-SR04 front end producing the dist_left/dist_right words consumed by motor_driver.
//  Alternately fires left then right trigger pulse, times the echo pulse, converts ticks to mm.
//  Also raises obstacle when either distance falls below a threshold (usable as motor stop).
// PARAMETERS
//  TRIG_TICKS      32      trigger high time in clocks (10.24 us @ 3.125 MHz)
//  RISE_TIMEOUT    31250   max clocks from trigger end to echo rise (10 ms)
//  ECHO_TIMEOUT    118750  max echo high time in clocks (38 ms)
//  GAP_TICKS       187500  idle clocks after each channel before next trigger (60 ms)
//  MAX_DIST        16'd4000 distance (mm) reported on any timeout
//  STOP_DIST       16'd150 obstacle threshold (mm)
// PORTS
//  clk_3125KHz   in   1   system clock, 3.125 MHz
//  rst_n         in   1   asynchronous active-low reset
//  enable        in   1   1 = keep ranging; 0 = halt in IDLE after current channel completes
//  echo_left     in   1   left sensor echo, asynchronous
//  echo_right    in   1   right sensor echo, asynchronous
//  trig_left     out  1   left sensor trigger
//  trig_right    out  1   right sensor trigger
//  dist_left     out  16  last left distance, mm
//  dist_right    out  16  last right distance, mm
//  update        out  1   1-cycle pulse when a dist register is written
//  update_ch     out  1   channel of last update: 0 = left, 1 = right
//  obstacle      out  1   registered: (dist_left < STOP_DIST) | (dist_right < STOP_DIST)
// BEHAVIOUR
//  Reset: trig_* = 0, dist_* = MAX_DIST, update = 0, update_ch = 0, obstacle = 0, state IDLE, ch = left.
//  Echo inputs pass 2-flop synchronisers; FSM uses only the synced echo_s of the active channel.
//  Single 18-bit timer shared by all states; cleared on every state change.
//  IDLE: if enable, go to TRIG next cycle.
//  TRIG: trig_<ch> = 1 for exactly TRIG_TICKS cycles, then 0; go to WAIT_RISE.
//  WAIT_RISE: echo_s = 1 -> MEASURE with timer = 0.
//    timer reaches RISE_TIMEOUT -> write MAX_DIST, go to GAP.
//  MEASURE: timer increments each cycle echo_s = 1.
//    echo_s = 0 -> write dist = (ticks * 7) >> 7 (20-bit product, upper bits truncated to 16), go to GAP.
//    timer reaches ECHO_TIMEOUT -> write MAX_DIST, go to GAP without waiting for fall.
//  GAP: wait GAP_TICKS, toggle ch. Then: enable -> TRIG; else -> IDLE.
//  Write: dist_<ch> loaded on the edge leaving WAIT_RISE/MEASURE.
//    Same edge: update = 1 (next cycle low), update_ch = ch.
//  obstacle recomputed one cycle after any dist write.
//  enable is sampled only in IDLE and at GAP end; deasserting mid-channel does not abort it.
//  Only the active channel's trigger ever toggles; both triggers never high together.
//  Echo on inactive channel ignored. An echo already high when entering WAIT_RISE counts as rise.
//  Async reset mid-measurement: all outputs to reset values immediately; trig_* drop same instant.
//  Conversion: 0.32 us/tick * 343 m/s / 2 = 0.0549 mm/tick; 7/128 = 0.0547 (0.3% low, accepted).
// TESTING
//  Reset: assert rst_n=0 mid-TRIG -> trig_left=0 at once, dist_*=4000, obstacle=0, update=0.
//  enable=1, echo_left high 1000 clk after rise -> dist_left=54, update pulse 1 clk, update_ch=0.
//  Alternation: after left GAP, trig_right high 32 clk; echo_right 2000 clk -> dist_right=109, update_ch=1.
//  No echo rise for 31250 clk -> dist=4000 on timeout edge, then GAP of 187500 clk.
//  Echo stuck high 118750 clk -> dist=4000, FSM in GAP while echo still high.
//  echo_left 2000 clk -> dist_left=109 < 150 -> obstacle=1 next cycle.
//    Then echo_left 5000 clk -> dist_left=273 -> obstacle=0.
//  enable dropped during MEASURE -> measurement completes, GAP completes, IDLE, no further trig.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// Dual-channel HC-SR04 ranger: alternately triggers left/right sensors, times the echo,
// converts ticks to millimetres and flags an obstacle when either distance is short.
module ultrasonic_ranger #(
    parameter int          TRIG_TICKS   = 32,
    parameter int          RISE_TIMEOUT = 31250,
    parameter int          ECHO_TIMEOUT = 118750,
    parameter int          GAP_TICKS    = 187500,
    parameter logic [15:0] MAX_DIST     = 16'd4000,
    parameter logic [15:0] STOP_DIST    = 16'd150
) (
    input  logic        clk_3125KHz,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        echo_left,
    input  logic        echo_right,
    output logic        trig_left,
    output logic        trig_right,
    output logic [15:0] dist_left,
    output logic [15:0] dist_right,
    output logic        update,
    output logic        update_ch,
    output logic        obstacle
);

    localparam logic [17:0] TRIG_LAST = 18'(TRIG_TICKS - 1);
    localparam logic [17:0] RISE_LAST = 18'(RISE_TIMEOUT - 1);
    localparam logic [17:0] ECHO_LAST = 18'(ECHO_TIMEOUT - 1);
    localparam logic [17:0] GAP_LAST  = 18'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } state_t;

    state_t      state_reg, state_next;
    logic [17:0] timer_reg, timer_next;
    logic        ch_reg, ch_next;
    logic        update_reg;
    logic        update_ch_reg;
    logic        obstacle_reg;

    logic        wr_en;
    logic [15:0] wr_val;
    logic        echo_s;
    logic [1:0]  echo_raw;
    logic [1:0]  echo_sync;
    logic [19:0] product;
    logic [15:0] dist_conv;

    assign echo_raw = {echo_right, echo_left};

    // Per-channel synchroniser, trigger flop and distance register (index 0 = left, 1 = right)
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [1:0]  sync_reg;
        logic        trig_reg;
        logic [15:0] dist_reg;

        always_ff @(posedge clk_3125KHz or negedge rst_n) begin
            if (!rst_n) begin
                sync_reg <= 2'b00;
                trig_reg <= 1'b0;
                dist_reg <= MAX_DIST;
            end else begin
                sync_reg <= {sync_reg[0], echo_raw[gi]};
                trig_reg <= (state_next == TRIG) && (ch_next == 1'(gi));
                if (wr_en && (ch_reg == 1'(gi))) begin
                    dist_reg <= wr_val;
                end
            end
        end

        assign echo_sync[gi] = sync_reg[1];
    end

    assign echo_s = ch_reg ? echo_sync[1] : echo_sync[0];

    // 0.32 us/tick at 343 m/s round trip is ~0.0549 mm/tick, approximated by 7/128
    assign product   = {2'b00, timer_reg} * 20'd7;
    assign dist_conv = {3'b000, product[19:7]};

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg + 18'd1;
        ch_next    = ch_reg;
        wr_en      = 1'b0;
        wr_val     = MAX_DIST;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = TRIG;
                end
            end
            TRIG: begin
                if (timer_reg == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_s) begin
                    state_next = MEASURE;
                end else if (timer_reg == RISE_LAST) begin
                    wr_en      = 1'b1;
                    state_next = GAP;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    wr_en      = 1'b1;
                    wr_val     = dist_conv;
                    state_next = GAP;
                end else if (timer_reg == ECHO_LAST) begin
                    wr_en      = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (timer_reg == GAP_LAST) begin
                    ch_next    = ~ch_reg;
                    state_next = enable ? TRIG : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            timer_next = 18'd0;
        end
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            timer_reg     <= 18'd0;
            ch_reg        <= 1'b0;
            update_reg    <= 1'b0;
            update_ch_reg <= 1'b0;
            obstacle_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            ch_reg       <= ch_next;
            update_reg   <= wr_en;
            obstacle_reg <= (g_ch[0].dist_reg < STOP_DIST) || (g_ch[1].dist_reg < STOP_DIST);
            if (wr_en) begin
                update_ch_reg <= ch_reg;
            end
        end
    end

    assign trig_left  = g_ch[0].trig_reg;
    assign trig_right = g_ch[1].trig_reg;
    assign dist_left  = g_ch[0].dist_reg;
    assign dist_right = g_ch[1].dist_reg;
    assign update     = update_reg;
    assign update_ch  = update_ch_reg;
    assign obstacle   = obstacle_reg;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomised bench for ultrasonic_ranger: drives echo pulses per channel and compares
// distances, update/obstacle behaviour and timing against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

    localparam int          TRIG  = 8;
    localparam int          RT    = 300;
    localparam int          ET    = 6000;
    localparam int          GAP   = 200;
    localparam logic [15:0] MAXD  = 16'd4000;
    localparam logic [15:0] STOP  = 16'd150;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        echo_left = 1'b0;
    logic        echo_right = 1'b0;
    logic        trig_left, trig_right;
    logic [15:0] dist_left, dist_right;
    logic        update, update_ch, obstacle;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int overlap = 0;
    int last_upd = 0;
    bit gap_valid = 0;
    logic [15:0] exp_dist [2];

    ultrasonic_ranger #(
        .TRIG_TICKS  (TRIG),
        .RISE_TIMEOUT(RT),
        .ECHO_TIMEOUT(ET),
        .GAP_TICKS   (GAP),
        .MAX_DIST    (MAXD),
        .STOP_DIST   (STOP)
    ) dut (
        .clk_3125KHz(clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .echo_left  (echo_left),
        .echo_right (echo_right),
        .trig_left  (trig_left),
        .trig_right (trig_right),
        .dist_left  (dist_left),
        .dist_right (dist_right),
        .update     (update),
        .update_ch  (update_ch),
        .obstacle   (obstacle)
    );

    always #160 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trig_left && trig_right) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Echo high for 'width' clocks: the first synchronised high cycle is the rise itself,
    // the remaining width-1 cycles are counted; a count reaching ET is a timeout.
    function automatic logic [15:0] model_dist(input int width);
        int ticks;
        if (width == 0) return MAXD;
        ticks = width - 1;
        if (ticks >= ET) return MAXD;
        return 16'((ticks * 7) / 128);
    endfunction

    task automatic set_echo(input bit ch, input bit val);
        if (ch) echo_right = val;
        else    echo_left  = val;
    endtask

    task automatic run_ch(input bit ch, input int delay, input int width, input bit drop_en);
        int          cnt;
        int          ucnt;
        logic [15:0] exp;
        exp = model_dist(width);

        cnt = 0;
        while (!(ch ? trig_right : trig_left) && cnt < GAP + RT + ET + 1000) begin
            @(negedge clk);
            cnt++;
        end
        if (!(ch ? trig_right : trig_left)) begin
            check("trig_start", 0, 1);
            return;
        end
        if (gap_valid) check("gap_len", cyc - last_upd, GAP);
        check("trig_other", ch ? trig_left : trig_right, 0);

        cnt = 0;
        while ((ch ? trig_right : trig_left) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("trig_width", cnt, TRIG);

        fork
            begin
                repeat (delay) @(negedge clk);
                if (width > 0) begin
                    set_echo(ch, 1'b1);
                    for (int i = 0; i < width; i++) begin
                        if (drop_en && i == 10) enable = 1'b0;
                        set_echo(!ch, 1'($urandom_range(0, 1)));
                        @(negedge clk);
                    end
                    set_echo(ch, 1'b0);
                    set_echo(!ch, 1'b0);
                end
            end
            begin
                ucnt = 0;
                while (!update && ucnt < delay + width + RT + 50) begin
                    @(negedge clk);
                    ucnt++;
                end
                check("update_seen", update, 1);
                if (update) begin
                    if (width == 0) check("rise_timeout_len", ucnt, RT);
                    if (width - 1 >= ET) check("echo_still_high", ch ? echo_right : echo_left, 1);
                    check(ch ? "dist_right" : "dist_left", ch ? dist_right : dist_left, exp);
                    check("other_dist", ch ? dist_left : dist_right, exp_dist[!ch]);
                    check("update_ch", update_ch, ch);
                    exp_dist[ch] = exp;
                    last_upd = cyc;
                    gap_valid = 1;
                    @(negedge clk);
                    check("update_pulse", update, 0);
                    check("obstacle", obstacle, (exp_dist[0] < STOP) || (exp_dist[1] < STOP));
                    $display("txn ch=%0d delay=%0d width=%0d dist=%0d obstacle=%0d",
                             ch, delay, width, exp, obstacle);
                end
            end
        join
    endtask

    initial begin
        bit ch;
        int cnt;
        exp_dist[0] = MAXD;
        exp_dist[1] = MAXD;

        repeat (3) @(negedge clk);
        check("rst_trig_left", trig_left, 0);
        check("rst_trig_right", trig_right, 0);
        check("rst_dist_left", dist_left, MAXD);
        check("rst_dist_right", dist_right, MAXD);
        check("rst_update", update, 0);
        check("rst_update_ch", update_ch, 0);
        check("rst_obstacle", obstacle, 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        run_ch(0, 100, 1000, 0);
        run_ch(1, 50, 2000, 0);
        run_ch(0, 0, 0, 0);
        run_ch(1, 20, ET + 50, 0);
        run_ch(0, 30, 2000, 0);
        run_ch(1, 30, 5000, 0);
        run_ch(0, 30, 5000, 0);

        ch = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 3000));
            run_ch(ch, int'($urandom_range(0, RT - 20)), w, 0);
            ch = !ch;
        end

        // Asynchronous reset while a trigger pulse is high
        cnt = 0;
        while (!(trig_left || trig_right) && cnt < GAP + RT + ET + 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("pre_reset_trig", trig_left || trig_right, 1);
        repeat (3) @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("async_trig_left", trig_left, 0);
        check("async_trig_right", trig_right, 0);
        check("async_dist_left", dist_left, MAXD);
        check("async_dist_right", dist_right, MAXD);
        check("async_update", update, 0);
        check("async_obstacle", obstacle, 0);
        check("async_update_ch", update_ch, 0);
        exp_dist[0] = MAXD;
        exp_dist[1] = MAXD;
        gap_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Dropping enable mid-measurement lets the channel and its gap finish, then halts
        run_ch(0, 40, 1500, 1);
        cnt = 0;
        for (int i = 0; i < GAP + RT + 100; i++) begin
            @(negedge clk);
            if (trig_left || trig_right) cnt++;
        end
        check("no_trig_after_disable", cnt, 0);
        check("trig_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
